hls_divider: RTL and testbench

- Hand-written multi-cycle unsigned divider exposing the same start_port/done_port/return_port handshake as the HLS-generated accelerators.
- A top-level controller can swap it in as a drop-in callee, with the divider acting as responder.
- Restoring division, one quotient bit per cycle.
- Returns the quotient on return_port and the remainder on rem_port.

---
 rtl/hls_divider_pkg.sv | 13 +
 rtl/hls_divider_div_step.sv | 23 ++
 rtl/hls_divider.sv | 82 ++++++++
 tb/tb_hls_divider.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hls_divider_pkg.sv
// Shared handshake definitions for hand-written HLS-compatible responders:
// FSM encodings and the default datapath width.
package hls_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } hs_state_e;

  localparam int HLS_DEF_WIDTH = 64;

endpackage

// File: rtl/hls_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only if it did not go negative.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] r,
  input  logic             din,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] r_nxt,
  output logic             q_bit
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] t;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the difference's top bit is a pure sign bit.
  assign sh    = {r, din};
  assign t     = sh - {1'b0, dvs};
  assign q_bit = ~t[WIDTH];
  assign r_nxt = q_bit ? t[WIDTH-1:0] : sh[WIDTH-1:0];

endmodule

// File: rtl/hls_divider.sv
// Multi-cycle unsigned restoring divider behind the start/done/return
// handshake used by the generated accelerators; one quotient bit per cycle.
module hls_divider
  import hls_divider_pkg::*;
#(
  parameter int WIDTH = HLS_DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_port,
  input  logic [WIDTH-1:0] Pd5,
  input  logic [WIDTH-1:0] Pd6,
  output logic             done_port,
  output logic [WIDTH-1:0] return_port,
  output logic [WIDTH-1:0] rem_port
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  hs_state_e        state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_nxt;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r     (r),
    .din   (dvd[WIDTH-1]),
    .dvs   (dvs),
    .r_nxt (r_nxt),
    .q_bit (q_bit)
  );

  // Quotient bits enter at the LSB as dividend bits leave the MSB, so after
  // WIDTH steps the dividend register holds the quotient.
  assign dvd_nxt = {dvd[WIDTH-2:0], q_bit};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      done_port   <= 1'b0;
      return_port <= '0;
      rem_port    <= '0;
      dvd         <= '0;
      dvs         <= '0;
      r           <= '0;
      cnt         <= '0;
    end else begin
      done_port <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_port) begin
            dvd   <= Pd5;
            dvs   <= Pd6;
            r     <= '0;
            cnt   <= CW'(WIDTH - 1);
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          r   <= r_nxt;
          dvd <= dvd_nxt;
          if (cnt == '0) begin
            state       <= DONE;
            done_port   <= 1'b1;
            return_port <= dvd_nxt;
            rem_port    <= r_nxt;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_divider.sv
// Directed bench for hls_divider at WIDTH=64 and WIDTH=8 with hand-computed
// quotients, remainders and done latencies.
module tb_hls_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        start64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        done64;
  logic [63:0] q64, r64;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        done8;
  logic [7:0]  q8, r8;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hls_divider #(.WIDTH(64)) dut64 (
    .clock(clock), .reset(reset), .start_port(start64), .Pd5(a64), .Pd6(b64),
    .done_port(done64), .return_port(q64), .rem_port(r64)
  );

  hls_divider #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start_port(start8), .Pd5(a8), .Pd6(b8),
    .done_port(done8), .return_port(q8), .rem_port(r8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until done64 rises; 0 means already high.
  task automatic wait64(output int lat);
    lat = 0;
    while (done64 !== 1'b1 && lat < 300) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (done8 !== 1'b1 && lat < 300) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // Launches a 64-bit divide; returns at the negedge right after the accepting edge.
  task automatic go64(input logic [63:0] a, input logic [63:0] b);
    @(negedge clock);
    a64 = a; b64 = b; start64 = 1'b1;
    @(negedge clock);
    start64 = 1'b0;
  endtask

  task automatic run64(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] eq, input logic [63:0] er);
    int lat;
    go64(a, b);
    wait64(lat);
    chk({tag, " lat"}, 64'(lat), 64'd64);
    chk({tag, " q"}, q64, eq);
    chk({tag, " r"}, r64, er);
    @(negedge clock);
    chk({tag, " pulse"}, 64'(done64), 64'd0);
    chk({tag, " q held"}, q64, eq);
    chk({tag, " r held"}, r64, er);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er);
    int lat;
    @(negedge clock);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    wait8(lat);
    chk({tag, " lat"}, 64'(lat), 64'd8);
    chk({tag, " q"}, 64'(q8), 64'(eq));
    chk({tag, " r"}, 64'(r8), 64'(er));
    @(negedge clock);
    chk({tag, " pulse"}, 64'(done8), 64'd0);
  endtask

  initial begin
    int lat;
    int ndone;

    #12;
    chk("rst done64", 64'(done64), 64'd0);
    chk("rst q64", q64, 64'd0);
    chk("rst r64", r64, 64'd0);
    chk("rst done8", 64'(done8), 64'd0);
    chk("rst q8", 64'(q8), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    run64("basic", 64'd100, 64'd7, 64'd14, 64'd2);
    run64("div0", 64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10);
    run64("zero dvd", 64'd0, 64'd9, 64'd0, 64'd0);

    // Start pulse with different operands while busy must be ignored.
    go64(64'd1000, 64'd10);
    repeat (19) @(negedge clock);
    a64 = 64'd5; b64 = 64'd5; start64 = 1'b1;
    @(negedge clock);
    start64 = 1'b0;
    wait64(lat);
    chk("busy lat", 64'(lat + 20), 64'd64);
    chk("busy q", q64, 64'd100);
    chk("busy r", r64, 64'd0);
    ndone = 0;
    repeat (80) begin
      @(negedge clock);
      if (done64) ndone++;
    end
    chk("busy no 2nd done", 64'(ndone), 64'd0);

    // Back-to-back: start held high, second operands presented in DONE.
    @(negedge clock);
    a64 = 64'd9; b64 = 64'd2; start64 = 1'b1;
    @(negedge clock);
    wait64(lat);
    chk("b2b lat1", 64'(lat), 64'd64);
    chk("b2b q1", q64, 64'd4);
    chk("b2b r1", r64, 64'd1);
    a64 = 64'd255; b64 = 64'd16;
    @(negedge clock);
    start64 = 1'b0;
    chk("b2b gap pulse", 64'(done64), 64'd0);
    wait64(lat);
    chk("b2b gap", 64'(lat + 1), 64'd65);
    chk("b2b q2", q64, 64'd15);
    chk("b2b r2", r64, 64'd15);

    // Reset mid-operation clears outputs at once and produces no done.
    go64(64'd50, 64'd3);
    repeat (29) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort q", q64, 64'd0);
    chk("abort r", r64, 64'd0);
    chk("abort done", 64'(done64), 64'd0);
    ndone = 0;
    repeat (3) begin
      @(negedge clock);
      if (done64) ndone++;
    end
    reset = 1'b1;
    repeat (60) begin
      @(negedge clock);
      if (done64) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);
    run64("after abort", 64'd50, 64'd3, 64'd16, 64'd2);

    run8("w8 255/1", 8'd255, 8'd1, 8'd255, 8'd0);
    run8("w8 7/255", 8'd7, 8'd255, 8'd0, 8'd7);
    run8("w8 128/128", 8'd128, 8'd128, 8'd1, 8'd0);
    run8("w8 200/0", 8'd200, 8'd0, 8'd255, 8'd200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
